fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Stall_in  input  1  SHALL hold the PC and the IF/ID register (load-use hazard).
REQ-005 Flush_in  input  1  SHALL force a bubble into IF/ID on the next edge.
REQ-006 PCSrc_in  input  1  SHALL select a taken branch resolved in MEM; BranchTarget_in  input  32  is its target.
REQ-007 JumpControl_in  input  1  SHALL select a J-type jump; Jump_SL2_in  input  32  is the decode-stage shifted 26-bit field.
REQ-008 JRegControl_in  input  1  SHALL select a register jump; JRegTarget_in  input  32  is the Rs value.
REQ-009 InstrAddr_out  output  32  SHALL be the current PC, driven to instruction memory.
REQ-010 InstrMem_in  input  32  SHALL be the instruction memory read data for InstrAddr_out, same cycle.
REQ-011 Instruction_out  output  32; PCPlus4_out  output  32; Valid_out  output  1: the IF/ID register contents feeding decode.
REQ-012 FetchCount_out  output  32  SHALL count valid instructions latched into IF/ID.

Function
REQ-013 Next-PC priority SHALL be: PCSrc_in -> BranchTarget_in; else JRegControl_in -> JRegTarget_in; else JumpControl_in -> {PC+4[31:28], Jump_SL2_in[27:0]}; else PC+4.
REQ-014 Every PC load SHALL force bits [1:0] to 2'b00.
REQ-015 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-016 Stall_in=1 with PCSrc_in=0 SHALL hold PC, Instruction_out, PCPlus4_out, Valid_out, FetchCount_out; jump inputs are ignored while stalled.
REQ-017 PCSrc_in=1 SHALL load BranchTarget_in into PC even when Stall_in=1.
REQ-018 A taken redirect (PCSrc_in, JRegControl_in or JumpControl_in, when not ignored per REQ-016) SHALL load a bubble into IF/ID.
REQ-019 Flush_in=1 SHALL load a bubble into IF/ID and override Stall_in for IF/ID; the PC follows REQ-013/016/017.
REQ-020 Bubble SHALL be Instruction_out=32'h0000_0000 (NOP), PCPlus4_out=32'h0, Valid_out=0.
REQ-021 Otherwise IF/ID SHALL load InstrMem_in, PC+4, Valid_out=1; latency from PC to Instruction_out is one cycle.
REQ-022 FetchCount_out SHALL increment by 1 on each edge that loads Valid_out=1, wrapping at 2^32.

Reset
REQ-023 Rst=0 SHALL immediately set PC=RESET_PC, Instruction_out=0, PCPlus4_out=0, Valid_out=0, FetchCount_out=0, independent of Clk.
REQ-024 Reset asserted mid-operation SHALL discard any pending redirect or stall; the first edge after release fetches from RESET_PC.

Structure
REQ-025 A shared package SHALL hold NOP_INSTR (32'h0), PC_INCR (4) and the RESET_PC default.
REQ-026 The PC register with its next-PC mux SHALL be one sub-module, pc_register; the IF/ID register and counter stay in fetch_stage.

Verification
REQ-027 Reset release, no control inputs, mem returns addr -> InstrAddr_out 0,4,8,12; Instruction_out lags one cycle; FetchCount_out 1,2,3.
REQ-028 Stall_in high 2 cycles at PC=0x10 -> PC, IF/ID and count frozen 2 cycles, then fetch resumes at 0x14.
REQ-029 JumpControl_in=1, Jump_SL2_in=0x0000_0100 at PC=0x20 -> next PC 0x100; IF/ID bubble; count unchanged that edge.
REQ-030 PCSrc_in=1, BranchTarget_in=0x40, Stall_in=1, JumpControl_in=1 same cycle -> PC 0x40, IF/ID bubble.
REQ-031 PC=0xFFFF_FFFC, no redirect -> next PC 0x0, PCPlus4_out 0x0, Valid_out=1; JRegTarget_in=0x33 -> PC 0x30.
REQ-032 Rst asserted mid-stall between edges -> outputs zero immediately; after release fetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared constants, next-PC select encoding and PC helpers for
//            the instruction fetch stage.
// Revision : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Source chosen for the next PC value
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JREG   = 3'd3,
    SEL_JUMP   = 3'd4
  } pc_sel_t;

  // Instruction addresses are word aligned; low two bits are always cleared.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // J-type target: upper nibble of the sequential PC plus the shifted field.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] sl2);
    return {pc_plus4[31:28], sl2[27:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Control, instruction-memory and IF/ID signals of the fetch
//            stage. "slave" is the fetch stage, "master" its environment.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if;

  logic        stall_in;
  logic        flush_in;
  logic        pcsrc_in;
  logic [31:0] branch_target_in;
  logic        jump_control_in;
  logic [31:0] jump_sl2_in;
  logic        jreg_control_in;
  logic [31:0] jreg_target_in;
  logic [31:0] instr_addr_out;
  logic [31:0] instr_mem_in;
  logic [31:0] instruction_out;
  logic [31:0] pcplus4_out;
  logic        valid_out;
  logic [31:0] fetch_count_out;

  modport slave (
    input  stall_in, flush_in, pcsrc_in, branch_target_in,
           jump_control_in, jump_sl2_in, jreg_control_in, jreg_target_in,
           instr_mem_in,
    output instr_addr_out, instruction_out, pcplus4_out, valid_out,
           fetch_count_out
  );

  modport master (
    output stall_in, flush_in, pcsrc_in, branch_target_in,
           jump_control_in, jump_sl2_in, jreg_control_in, jreg_target_in,
           instr_mem_in,
    input  instr_addr_out, instruction_out, pcplus4_out, valid_out,
           fetch_count_out
  );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_pc_register.sv
`default_nettype none
// ============================================================================
// Module   : pc_register
// Purpose  : Program counter with prioritised next-PC selection. A taken
//            branch wins even over a stall; jumps are ignored while stalled.
// Revision : 1.0  initial release
// ============================================================================
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_stall,
  input  wire logic        i_pcsrc,
  input  wire logic [31:0] i_branch_target,
  input  wire logic        i_jreg_control,
  input  wire logic [31:0] i_jreg_target,
  input  wire logic        i_jump_control,
  input  wire logic [31:0] i_jump_sl2,
  output      logic [31:0] o_pc,
  output      logic [31:0] o_pc_plus4,
  output      logic        o_redirect
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  pc_sel_t     w_sel;

  assign w_pc_plus4 = r_pc + PC_INCR;

  // Resolve which source drives the next PC, highest priority first
  always_comb begin
    w_sel = SEL_SEQ;
    if (i_pcsrc)             w_sel = SEL_BRANCH;
    else if (i_stall)        w_sel = SEL_HOLD;
    else if (i_jreg_control) w_sel = SEL_JREG;
    else if (i_jump_control) w_sel = SEL_JUMP;
  end

  // Next-PC mux; every loaded value is forced to word alignment
  always_comb begin
    w_pc_next = w_pc_plus4;
    case (w_sel)
      SEL_HOLD:   w_pc_next = r_pc;
      SEL_BRANCH: w_pc_next = align_pc(i_branch_target);
      SEL_JREG:   w_pc_next = align_pc(i_jreg_target);
      SEL_JUMP:   w_pc_next = align_pc(jump_target(w_pc_plus4, i_jump_sl2));
      default:    w_pc_next = w_pc_plus4;
    endcase
  end

  // PC register, asynchronously returned to the reset vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= align_pc(RESET_PC);
    else        r_pc <= w_pc_next;
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;
  assign o_redirect = (w_sel == SEL_BRANCH) || (w_sel == SEL_JREG) ||
                      (w_sel == SEL_JUMP);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage: PC register, IF/ID pipeline register
//            and a counter of valid instructions handed to decode.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  fetch_stage_if.slave bus
);

  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        w_redirect;
  logic        w_bubble;
  logic        w_load_valid;

  logic [31:0] r_instruction;
  logic [31:0] r_pcplus4;
  logic        r_valid;
  logic [31:0] r_fetch_count;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_stall         (bus.stall_in),
    .i_pcsrc         (bus.pcsrc_in),
    .i_branch_target (bus.branch_target_in),
    .i_jreg_control  (bus.jreg_control_in),
    .i_jreg_target   (bus.jreg_target_in),
    .i_jump_control  (bus.jump_control_in),
    .i_jump_sl2      (bus.jump_sl2_in),
    .o_pc            (w_pc),
    .o_pc_plus4      (w_pc_plus4),
    .o_redirect      (w_redirect)
  );

  // A flush or a taken redirect squashes the fetched word; flush beats stall
  assign w_bubble     = bus.flush_in || w_redirect;
  assign w_load_valid = !w_bubble && !bus.stall_in;

  // IF/ID register: bubble, hold on stall, or capture the fetched word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instruction <= NOP_INSTR;
      r_pcplus4     <= '0;
      r_valid       <= 1'b0;
    end else if (w_bubble) begin
      r_instruction <= NOP_INSTR;
      r_pcplus4     <= '0;
      r_valid       <= 1'b0;
    end else if (!bus.stall_in) begin
      r_instruction <= bus.instr_mem_in;
      r_pcplus4     <= w_pc_plus4;
      r_valid       <= 1'b1;
    end
  end

  // Count every valid instruction latched into IF/ID (wraps naturally)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_fetch_count <= '0;
    else if (w_load_valid) r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign bus.instr_addr_out  = w_pc;
  assign bus.instruction_out = r_instruction;
  assign bus.pcplus4_out     = r_pcplus4;
  assign bus.valid_out       = r_valid;
  assign bus.fetch_count_out = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed vector table,
//            reset corner sequence and randomized run against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [31:0] bt;
    logic        jc;
    logic [31:0] jsl2;
    logic        jrc;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_xor;
  int          n_vec;
  int          n_err;
  vec_t        tbl [25];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_p4, m_cnt;
  logic        m_valid;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory: returns the address, optionally scrambled
  assign bus.instr_mem_in = bus.instr_addr_out ^ mem_xor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic s, input logic f, input logic p,
                              input logic [31:0] bt, input logic jc,
                              input logic [31:0] jsl2, input logic jrc,
                              input logic [31:0] jrt, input logic [31:0] epc,
                              input logic [31:0] ei, input logic [31:0] ep4,
                              input logic ev, input logic [31:0] ec);
    vec_t v;
    v.stall = s;  v.flush = f; v.pcsrc = p; v.bt = bt;
    v.jc = jc;    v.jsl2 = jsl2; v.jrc = jrc; v.jrt = jrt;
    v.e_pc = epc; v.e_instr = ei; v.e_p4 = ep4; v.e_valid = ev; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] p4,
                           input logic v, input logic [31:0] cnt);
    check({tag, " pc"},    bus.instr_addr_out,  pc);
    check({tag, " instr"}, bus.instruction_out, ins);
    check({tag, " pc4"},   bus.pcplus4_out,     p4);
    check({tag, " valid"}, {31'd0, bus.valid_out}, {31'd0, v});
    check({tag, " count"}, bus.fetch_count_out, cnt);
  endtask

  task automatic drive(input logic s, input logic f, input logic p,
                       input logic [31:0] bt, input logic jc,
                       input logic [31:0] jsl2, input logic jrc,
                       input logic [31:0] jrt);
    bus.stall_in = s;  bus.flush_in = f; bus.pcsrc_in = p;
    bus.branch_target_in = bt; bus.jump_control_in = jc;
    bus.jump_sl2_in = jsl2; bus.jreg_control_in = jrc; bus.jreg_target_in = jrt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: one edge of the fetch stage from its rules
  task automatic model_step();
    logic [31:0] seq, nxt;
    logic        taken;
    seq   = m_pc + 32'd4;
    taken = 1'b0;
    if (bus.pcsrc_in) begin
      nxt = bus.branch_target_in & ~32'd3; taken = 1'b1;
    end else if (bus.stall_in) begin
      nxt = m_pc;
    end else if (bus.jreg_control_in) begin
      nxt = bus.jreg_target_in & ~32'd3; taken = 1'b1;
    end else if (bus.jump_control_in) begin
      nxt = ((seq & 32'hF000_0000) | (bus.jump_sl2_in & 32'h0FFF_FFFF)) & ~32'd3;
      taken = 1'b1;
    end else begin
      nxt = seq;
    end
    if (bus.flush_in || taken) begin
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
    end else if (!bus.stall_in) begin
      m_instr = m_pc ^ mem_xor; m_p4 = seq; m_valid = 1'b1; m_cnt = m_cnt + 1;
    end
    m_pc = nxt;
  endtask

  initial begin
    n_vec = 0; n_err = 0; mem_xor = 32'h0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table: {stall,flush,pcsrc,bt,jc,jsl2,jrc,jrt} -> {pc,instr,pc4,valid,count}
    tbl[0]  = mk(0,0,0,0,0,0,0,0, 32'h4, 32'h0, 32'h4, 1, 1);
    tbl[1]  = mk(0,0,0,0,0,0,0,0, 32'h8, 32'h4, 32'h8, 1, 2);
    tbl[2]  = mk(0,0,0,0,0,0,0,0, 32'hC, 32'h8, 32'hC, 1, 3);
    tbl[3]  = mk(0,0,0,0,0,0,0,0, 32'h10, 32'hC, 32'h10, 1, 4);
    tbl[4]  = mk(1,0,0,0,0,0,0,0, 32'h10, 32'hC, 32'h10, 1, 4);
    tbl[5]  = mk(1,0,0,0,1,32'h100,0,0, 32'h10, 32'hC, 32'h10, 1, 4);
    tbl[6]  = mk(0,0,0,0,0,0,0,0, 32'h14, 32'h10, 32'h14, 1, 5);
    tbl[7]  = mk(0,0,0,0,0,0,0,0, 32'h18, 32'h14, 32'h18, 1, 6);
    tbl[8]  = mk(0,0,0,0,0,0,0,0, 32'h1C, 32'h18, 32'h1C, 1, 7);
    tbl[9]  = mk(0,0,0,0,0,0,0,0, 32'h20, 32'h1C, 32'h20, 1, 8);
    tbl[10] = mk(0,0,0,0,1,32'h100,0,0, 32'h100, 32'h0, 32'h0, 0, 8);
    tbl[11] = mk(0,0,0,0,0,0,0,0, 32'h104, 32'h100, 32'h104, 1, 9);
    tbl[12] = mk(1,0,1,32'h40,1,32'h200,0,0, 32'h40, 32'h0, 32'h0, 0, 9);
    tbl[13] = mk(0,1,0,0,0,0,0,0, 32'h44, 32'h0, 32'h0, 0, 9);
    tbl[14] = mk(1,1,0,0,0,0,0,0, 32'h44, 32'h0, 32'h0, 0, 9);
    tbl[15] = mk(0,0,0,0,0,0,1,32'h33, 32'h30, 32'h0, 32'h0, 0, 9);
    tbl[16] = mk(0,0,0,0,1,32'h300,1,32'h80, 32'h80, 32'h0, 32'h0, 0, 9);
    tbl[17] = mk(0,0,1,32'h1000,0,0,1,32'h80, 32'h1000, 32'h0, 32'h0, 0, 9);
    tbl[18] = mk(0,0,1,32'hFFFF_FFFE,0,0,0,0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 9);
    tbl[19] = mk(0,0,0,0,0,0,0,0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 10);
    tbl[20] = mk(0,0,0,0,0,0,0,0, 32'h4, 32'h0, 32'h4, 1, 11);
    tbl[21] = mk(0,0,1,32'h7000_0000,0,0,0,0, 32'h7000_0000, 32'h0, 32'h0, 0, 11);
    tbl[22] = mk(0,0,0,0,1,32'h0FFF_FFF0,0,0, 32'h7FFF_FFF0, 32'h0, 32'h0, 0, 11);
    tbl[23] = mk(0,0,0,0,1,32'hF000_0100,0,0, 32'h7000_0100, 32'h0, 32'h0, 0, 11);
    tbl[24] = mk(0,0,0,0,0,0,0,0, 32'h7000_0104, 32'h7000_0100, 32'h7000_0104, 1, 12);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].pcsrc, tbl[i].bt,
            tbl[i].jc, tbl[i].jsl2, tbl[i].jrc, tbl[i].jrt);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_instr,
                tbl[i].e_p4, tbl[i].e_valid, tbl[i].e_cnt);
    end

    // Reset asserted between edges while stalled: outputs clear at once
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    // Pending branch and stall during reset are discarded
    drive(1, 0, 1, 32'h500, 1, 32'h600, 0, 0);
    tick();
    tick();
    check_all("rst_held", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("post_rst", 32'h4, 32'h0, 32'h4, 1'b1, 32'h1);

    // Randomized run against the model, starting from a fresh reset
    rst_n = 1'b0;
    #1;
    m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    mem_xor = 32'h1234_5678;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom);
      model_step();
      tick();
      check_all($sformatf("rnd%0d", c), m_pc, m_instr, m_p4, m_valid, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
